// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - RV32I data-memory stage: lane-steered word RAM, extended loads,
// sticky fault record and load/store counters.
module dmem_lsu #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  input  logic        err_clr,
  output logic [31:0] ReadDataM,
  output logic        fault,
  output logic        err_sticky,
  output logic [31:0] err_addr,
  output logic [31:0] load_count,
  output logic [31:0] store_count
);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] wordIdx;
  logic [1:0]    lane;
  logic          storeIllegal;
  logic          loadIllegal;
  logic          misaligned;
  logic [3:0]    byteEn;
  logic [31:0]   wrWord;
  logic [31:0]   rdWord;
  logic [7:0]    rdByte;
  logic [15:0]   rdHalf;
  logic [31:0]   loadVal;

  // Upper address bits are dropped, so the RAM aliases every 4*DEPTH_WORDS bytes.
  assign wordIdx = Mem_WrAddr[AW+1:2];
  assign lane    = Mem_WrAddr[1:0];

  assign storeIllegal = MemWriteM & !(funct3M inside {3'b000, 3'b001, 3'b010});
  assign loadIllegal  = MemReadM  & !(funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign misaligned   = ((funct3M[1:0] == 2'b01) & lane[0]) |
                        ((funct3M[1:0] == 2'b10) & (lane != 2'b00));
  assign fault        = (MemWriteM | MemReadM) & (misaligned | storeIllegal | loadIllegal);

  always_comb begin
    byteEn = 4'b0000;
    wrWord = Mem_WrData;
    case (funct3M)
      3'b000: begin
        byteEn = 4'b0001 << lane;
        wrWord = {4{Mem_WrData[7:0]}};
      end
      3'b001: begin
        byteEn = lane[1] ? 4'b1100 : 4'b0011;
        wrWord = {2{Mem_WrData[15:0]}};
      end
      3'b010:  byteEn = 4'b1111;
      default: byteEn = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && MemWriteM && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= wrWord[8*i +: 8];
      end
    end
  end

  assign rdWord = mem[wordIdx];
  assign rdByte = rdWord[8*lane +: 8];
  assign rdHalf = lane[1] ? rdWord[31:16] : rdWord[15:0];

  always_comb begin
    loadVal = 32'd0;
    case (funct3M)
      3'b000:  loadVal = {{24{rdByte[7]}}, rdByte};
      3'b100:  loadVal = {24'd0, rdByte};
      3'b001:  loadVal = {{16{rdHalf[15]}}, rdHalf};
      3'b101:  loadVal = {16'd0, rdHalf};
      3'b010:  loadVal = rdWord;
      default: loadVal = 32'd0;
    endcase
  end

  assign ReadDataM = (MemReadM && !fault) ? loadVal : 32'd0;

  // A clear coinciding with a fault behaves as clear-then-record.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky  <= 1'b0;
      err_addr    <= 32'd0;
      load_count  <= 32'd0;
      store_count <= 32'd0;
    end else begin
      if (fault) begin
        if (err_clr || !err_sticky) begin
          err_sticky <= 1'b1;
          err_addr   <= Mem_WrAddr;
        end
      end else if (err_clr) begin
        err_sticky <= 1'b0;
        err_addr   <= 32'd0;
      end
      if (MemReadM && !fault)  load_count  <= load_count + 32'd1;
      if (MemWriteM && !fault) store_count <= store_count + 32'd1;
    end
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Data-memory stage attached to the memory-stage outputs of the pipelined RV32I core: address, store data, funct3, store strobe.
- Performs byte/half/word stores with lane steering into an internal word-organised RAM.
- Returns sign- or zero-extended load data combinationally on ReadDataM, which the M/W pipeline register samples.
- Detects misaligned and illegal-width accesses, keeps a sticky fault record, and counts completed loads and stores.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit RAM words; must be a power of two.
- AW, 10: word-index width, equal to log2(DEPTH_WORDS).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- MemWriteM  in  1  store strobe from the M stage.
- MemReadM  in  1  load strobe from the M stage (ResultSrcM == 2'b01).
- funct3M  in  3  access width and signedness (RV32I encoding).
- Mem_WrAddr  in  32  byte address, equal to ALUResultM.
- Mem_WrData  in  32  store data, equal to WriteDataM, right-aligned.
- err_clr  in  1  clears the sticky fault record.
- ReadDataM  out  32  extended load data (combinational).
- fault  out  1  current access is faulting (combinational).
- err_sticky  out  1  a fault has occurred since the last clear.
- err_addr  out  32  address of the first fault since the last clear.
- load_count  out  32  number of completed loads.
- store_count  out  32  number of completed stores.

Behaviour:
- Word index: Mem_WrAddr[AW+1:2]. Upper address bits are ignored, so addresses alias modulo 4*DEPTH_WORDS. Lane: Mem_WrAddr[1:0].
- Store encodings:
  - 000 SB: byte enable = 1 << addr[1:0]; data[7:0] is replicated to all lanes.
  - 001 SH: enables 0011 or 1100 chosen by addr[1]; data[15:0] is replicated.
  - 010 SW: enables 1111.
  - Any other funct3 is illegal.
- Load encodings:
  - 000 LB and 100 LBU: select the byte at addr[1:0].
  - 001 LH and 101 LHU: select the half at addr[1].
  - 010 LW: full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Any other funct3 is illegal.
- Misalignment: halfword access with addr[0]=1, or word access with addr[1:0]!=00.
- fault = (MemWriteM | MemReadM) & (misaligned | illegal funct3).
- Store timing:
  - RAM write happens on the clk edge when MemWriteM=1, fault=0 and reset=0. Only enabled byte lanes change.
  - A faulting store writes nothing.
- Load timing:
  - ReadDataM is combinational from the current RAM contents: zero added latency, valid in the same cycle the M stage presents the address.
  - ReadDataM = 0 when MemReadM=0 or fault=1.
- MemWriteM and MemReadM both high: the store takes effect at the edge, and ReadDataM shows pre-write contents. Both counters increment if there is no fault.
- Reset:
  - err_sticky=0, err_addr=0, load_count=0, store_count=0.
  - RAM contents are not reset; the bench preloads them with $readmemh.
  - Reset asserted together with MemWriteM blocks the write.
- Fault record, updated on the edge:
  - fault & ~err_sticky: err_sticky←1, err_addr←Mem_WrAddr.
  - fault & err_sticky: no change (the first fault is retained).
  - err_clr & ~fault: err_sticky←0, err_addr←0.
  - err_clr & fault in the same cycle: treated as clear-then-record, so err_sticky=1 and err_addr takes the new address.
- Counters:
  - load_count increments on MemReadM & ~fault; store_count increments on MemWriteM & ~fault.
  - Both wrap from 0xFFFFFFFF to 0.
  - Faulting accesses are not counted.

Test Plan:
- SW 0xDEADBEEF to 0x100, next cycle LW from 0x100 → ReadDataM=0xDEADBEEF; store_count=1, load_count=1.
- Word 0x100=0x00000000; SB 0x80 to 0x101, then SH 0x1234 to 0x102 → LW=0x12348000, LB 0x101=0xFFFFFF80, LBU 0x101=0x00000080, LH 0x102=0x00001234.
- LH from 0x103 → ReadDataM=0 and fault=1; next edge err_sticky=1, err_addr=0x103. Then SW to 0x202 → RAM unchanged, err_addr stays 0x103, store_count unchanged.
- funct3=011 with MemWriteM=1 → no write, fault=1. Same cycle as err_clr=1 → err_sticky=1, err_addr=new address. Then err_clr alone → err_sticky=0, err_addr=0.
- Alias check with DEPTH_WORDS=1024: SW 0x11 to 0x1000 → LW 0x0000 returns 0x11. Reset asserted with MemWriteM=1 → RAM unchanged, counters=0.
- Preload store_count to 0xFFFFFFFF via force, then one SW → store_count=0.
